// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat is accepted this cycle (= ~out_valid | out_ready)
//   a, b       operands (unsigned or two's complement), WIDTH bits
//   cin        carry-in, only used for addition
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result present
//   out_ready  consumer takes the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (for sub: 1 = no borrow)
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//   zero       sum == 0
//
// Level k registers hold the beat that stage k works on next. Stage k
// resolves bits [k*GROUP +: GROUP] with a flat lookahead from the registered
// group carry; the finished groups overwrite the matching operand-A bits in
// the same word, so lower results stay deskewed while the upper operand
// groups are still waiting for their stage.
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / GROUP;

    if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a positive multiple of GROUP");
    end

    // Flat carry-lookahead: every carry is a sum of products of g/p and the
    // group carry-in, so no carry ripples through another inside the group.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c[0] = c0;
        for (int j = 1; j <= GROUP; j++) begin
            term = c0;
            for (int i = 0; i < j; i++) begin
                term = term & p[i];
            end
            c[j] = term;
            for (int i = 0; i < j; i++) begin
                term = g[i];
                for (int m = i + 1; m < j; m++) begin
                    term = term & p[m];
                end
                c[j] = c[j] | term;
            end
        end
        return c;
    endfunction

    // Per-level pipeline state
    logic             v_q [STAGES];  // beat valid
    logic             s_q [STAGES];  // sub bit travelling with the beat
    logic             c_q [STAGES];  // carry into this level's group
    logic [WIDTH-1:0] w_q [STAGES];  // {pending A groups, finished sum groups}
    logic [WIDTH-1:0] b_q [STAGES];  // pending B groups, current group at LSB

    // Stage outputs, next state of the following level
    logic             c_d [STAGES];
    logic [WIDTH-1:0] w_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic             msb_c_d;       // carry into the MSB, from the last stage

    // Output registers
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             adv;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    // The whole pipe moves together; a full output register blocks every level.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Selects this stage's group inside the full-width word. When
        // WIDTH == GROUP the shifted 1 falls off the top and the mask
        // becomes all ones, which is the intended result.
        localparam logic [WIDTH-1:0] GMASK =
            ((WIDTH'(1) << GROUP) - WIDTH'(1)) << (k * GROUP);

        logic [GROUP-1:0] ga;
        logic [GROUP-1:0] gb;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic [GROUP-1:0] gsum;

        assign ga   = w_q[k][k*GROUP +: GROUP];
        assign gb   = b_q[k][GROUP-1:0] ^ {GROUP{s_q[k]}};
        assign p    = ga ^ gb;
        assign g    = ga & gb;
        assign c    = cla_carries(p, g, c_q[k]);
        assign gsum = p ^ c[GROUP-1:0];

        assign w_d[k] = (w_q[k] & ~GMASK) | (WIDTH'(gsum) << (k * GROUP));
        assign b_d[k] = b_q[k] >> GROUP;
        assign c_d[k] = c[GROUP];

        if (k == STAGES - 1) begin : g_last
            assign msb_c_d = c[GROUP-1];
        end
    end

    assign sum_d  = w_d[STAGES-1];
    assign cout_d = c_d[STAGES-1];
    assign ovf_d  = c_d[STAGES-1] ^ msb_c_d;
    assign zero_d = (w_d[STAGES-1] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                w_q[k] <= '0;
                b_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            // Level 0 captures the raw operands; subtraction forces carry-in 1.
            v_q[0] <= in_valid;
            s_q[0] <= sub;
            c_q[0] <= sub ? 1'b1 : cin;
            w_q[0] <= a;
            b_q[0] <= b;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                s_q[k] <= s_q[k-1];
                c_q[k] <= c_d[k-1];
                w_q[k] <= w_d[k-1];
                b_q[k] <= b_d[k-1];
            end
            out_valid_q <= v_q[STAGES-1];
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - scoreboard bench for pipelined_cla_addsub (16-bit and 8-bit instances)
module tb_pipelined_cla_addsub;

    localparam int W  = 16;
    localparam int NS = 4;
    localparam int W8 = 8;
    localparam int NS8 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0]  a = '0, b = '0, sum;

    logic          in_valid8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b1;
    logic          in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [W8-1:0] a8 = '0, b8 = '0, sum8;

    pipelined_cla_addsub #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_addsub #(.WIDTH(W8), .GROUP(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         lat_chk;
        int           acc;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         si;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    exp_t q[$];
    exp_t q8[$];
    vec_t vecs[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov,
                                input logic z, input logic lat);
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = ov; e.zero = z; e.lat_chk = lat; e.acc = 0;
        return e;
    endfunction

    // Behavioural reference: plain wide addition, signs compared for overflow.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic ci, input logic si);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] s;
        bb   = si ? ~bi : bi;
        full = {1'b0, ai} + {1'b0, bb} + {{W{1'b0}}, (si ? 1'b1 : ci)};
        s    = full[W-1:0];
        return mk(s, full[W], (ai[W-1] == bb[W-1]) && (s[W-1] != ai[W-1]), s == '0, 1'b0);
    endfunction

    task automatic send16(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input logic si, input exp_t e);
        bit acc_ok = 0;
        int tries = 0;
        int acc = 0;
        a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
        while (!acc_ok && tries < 1000) begin
            @(negedge clk);
            acc_ok = in_ready;
            acc = cyc + 1;
            @(posedge clk);
            tries++;
        end
        if (acc_ok) begin
            e.acc = acc;
            q.push_back(e);
        end else begin
            total++; bad++;
            $display("FAIL accept16: in_ready stayed 0 for %0d cycles, expected acceptance", tries);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send8(input logic [W8-1:0] ai, input logic [W8-1:0] bi, input logic ci,
                         input logic si, input exp_t e);
        bit acc_ok = 0;
        int tries = 0;
        int acc = 0;
        a8 = ai; b8 = bi; cin8 = ci; sub8 = si; in_valid8 = 1'b1;
        while (!acc_ok && tries < 1000) begin
            @(negedge clk);
            acc_ok = in_ready8;
            acc = cyc + 1;
            @(posedge clk);
            tries++;
        end
        if (acc_ok) begin
            e.acc = acc;
            q8.push_back(e);
        end else begin
            total++; bad++;
            $display("FAIL accept8: in_ready stayed 0 for %0d cycles, expected acceptance", tries);
        end
        #1 in_valid8 = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d beats pending after %0d cycles, expected 0",
                     q.size(), q8.size(), limit);
            q.delete();
            q8.delete();
        end
        #1;
    endtask

    always @(posedge clk) begin
        #1 out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Scoreboard monitor, 16-bit instance: compares the head entry every cycle
    // the output is valid (so held outputs are rechecked while stalled) and
    // pops it on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready16", longint'(in_ready), longint'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected16: out_valid=1 sum=%0h, expected no output", sum);
                end else begin
                    chk("sum16",  longint'(sum),  longint'(q[0].sum));
                    chk("cout16", longint'(cout), longint'(q[0].cout));
                    chk("ovf16",  longint'(ovf),  longint'(q[0].ovf));
                    chk("zero16", longint'(zero), longint'(q[0].zero));
                    if (out_ready) begin
                        if (q[0].lat_chk) chk("latency16", longint'(cyc - q[0].acc), longint'(NS));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready8", longint'(in_ready8), longint'(!out_valid8 || out_ready8));
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected8: out_valid=1 sum=%0h, expected no output", sum8);
                end else begin
                    chk("sum8",  longint'(sum8),  longint'(q8[0].sum[W8-1:0]));
                    chk("cout8", longint'(cout8), longint'(q8[0].cout));
                    chk("ovf8",  longint'(ovf8),  longint'(q8[0].ovf));
                    chk("zero8", longint'(zero8), longint'(q8[0].zero));
                    if (out_ready8) begin
                        chk("latency8", longint'(cyc - q8[0].acc), longint'(NS8));
                        void'(q8.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        total++; bad++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        //          a        b        ci    si    sum      co    ov    z
        vecs.push_back({16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back({16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
        vecs.push_back({16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back({16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
        vecs.push_back({16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back({16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back({16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sum",       longint'(sum), 0);
        chk("rst_cout",      longint'(cout), 0);
        chk("rst_ovf",       longint'(ovf), 0);
        chk("rst_zero",      longint'(zero), 0);
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_out_valid8", longint'(out_valid8), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First vector alone into an empty pipe, then the rest back-to-back.
        send16(vecs[0].a, vecs[0].b, vecs[0].ci, vecs[0].si,
               mk(vecs[0].s, vecs[0].co, vecs[0].ov, vecs[0].z, 1'b1));
        wait_drain(50);
        for (int i = 1; i < vecs.size(); i++) begin
            send16(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].si,
                   mk(vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z, 1'b1));
        end
        wait_drain(50);

        // Back-to-back stream with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [31:0] rc;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            send16(ra[W-1:0], rb[W-1:0], rc[0], rc[1], model(ra[W-1:0], rb[W-1:0], rc[0], rc[1]));
        end
        wait_drain(500);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three beats in flight, the first already at the output.
        send16(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
        send16(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0, 1'b1));
        send16(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_sum",       longint'(sum), 0);
        chk("midrst_cout",      longint'(cout), 0);
        chk("midrst_ovf",       longint'(ovf), 0);
        chk("midrst_zero",      longint'(zero), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send16(16'h0FFF, 16'h0000, 1'b1, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b1));
        wait_drain(50);

        // Two-stage instance.
        send8(8'hF0, 8'h10, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1));
        wait_drain(50);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, mk(16'h0080, 1'b0, 1'b1, 1'b0, 1'b1));
        send8(8'h03, 8'h05, 1'b0, 1'b1, mk(16'h00FE, 1'b0, 1'b0, 1'b0, 1'b1));
        wait_drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit CLA.
- Operand width is split into GROUP-bit lookahead groups. One group is resolved per pipeline stage, and the group carry is registered between stages.
- Provides add/sub mode, status flags and a valid/ready handshake on both sides.
- Serves as the shared arithmetic unit for the clock's time-keeping and alarm-compare datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, lookahead group width in bits; each stage resolves one group.
- STAGES, WIDTH/GROUP, derived (localparam, not overridable); pipeline depth and latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1, cin ignored.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of MSB. For sub: 1 = no borrow (A>=B unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async assert, sync release): all valid bits cleared; sum=0, cout=0, ovf=0, zero=0, out_valid=0. in_ready=1 during the first cycle after release.
- Pipeline enable: adv = ~out_valid | out_ready. in_ready = adv, a combinational function of out_valid and out_ready only (no path from in_valid).
- Beat acceptance: a beat is accepted on a rising edge where in_valid & in_ready.
- Stall: when adv=0, every stage register holds, including valid bits and partial results. Nothing is dropped or duplicated.
- Stage k (0..STAGES-1):
  - Forms p=a^b' and g=a&b' on group k, where b' = sub ? ~b : b.
  - Computes group carries with full lookahead from the registered incoming carry. No ripple within a group.
  - Writes GROUP result bits; registers the group carry-out for stage k+1.
  - Stage 0 carry-in = sub ? 1 : cin.
- Operand skew: the unused upper operand groups and the sub bit travel alongside in skew registers. Completed lower result groups are delayed (deskewed) so all WIDTH bits emerge together.
- Flags: ovf requires the carry into the MSB, computed in the last stage. zero is computed from the full deskewed sum in the last stage, registered with sum.
- Latency: a beat accepted at edge t with no stall has out_valid=1 after edge t+STAGES. Stalls extend latency cycle-for-cycle.
- Throughput: one beat per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/zero are held stable.
- Bubbles travel as invalid stages and are not compressed. A stall holds bubbles too.
- Simultaneous accept and output: when the output is accepted and a new beat enters in the same cycle, all stages shift by one.
- Reset mid-operation: all in-flight beats are discarded immediately; no spurious out_valid after release.
- Width rules: sum wraps modulo 2^WIDTH. For sub, a - b is exact two's complement. WIDTH=GROUP gives a 1-stage registered CLA.
- Elaboration: WIDTH % GROUP != 0 is an elaboration error.

Test Plan:
- WIDTH=16: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles: sum=0x0000, cout=1, ovf=0, zero=1.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0, zero=0.
- Stream 20 random beats back-to-back with out_ready toggling pseudo-randomly -> results match a reference model in order. No loss or duplication. Outputs stable while stalled. in_ready tracks ~out_valid|out_ready.
- Assert rst_n low with 3 beats in flight -> outputs clear immediately. After release, out_valid stays 0 until a new beat has traversed 4 stages.
- WIDTH=8, GROUP=4 instance: 0xF0+0x10, cin=0 -> sum=0x00, cout=1, zero=1, out_valid exactly 2 cycles after acceptance.
